// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: load-use and branch hazards, fixed-latency
// MDU sequencing in EX, and a saturating stall-cycle counter.
//
// state | meaning
// IDLE  | no MDU op in flight; a new MduStartE begins a sequence
// BUSY  | MDU op held in EX; cnt counts down to the final (done) cycle
module pipeline_stall_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1D,
    input  logic [4:0]       RS2D,
    input  logic [4:0]       RdE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MduStartE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MduDone,
    output logic             MduBusy,
    output logic [CNT_W-1:0] StallCnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MDU_LAT - 2);

    state_t     state;
    logic [3:0] cnt;
    logic       mdu_stall;
    logic       lw_stall;

    always_comb begin
        mdu_stall = 1'b0;
        lw_stall  = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        MduDone   = 1'b0;
        MduBusy   = 1'b0;
        if (!rst) begin
            mdu_stall = ((state == IDLE) && MduStartE) || ((state == BUSY) && (cnt != 4'd0));
            // a taken branch squashes the dependent instruction, so no stall is needed
            lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((RS1D == RdE) || (RS2D == RdE))
                        && !PCSrcE && !mdu_stall;
            StallF    = lw_stall || mdu_stall;
            StallD    = lw_stall || mdu_stall;
            StallE    = mdu_stall;
            FlushM    = mdu_stall;
            FlushD    = PCSrcE && !mdu_stall;
            FlushE    = (lw_stall || PCSrcE) && !mdu_stall;
            MduDone   = (state == BUSY) && (cnt == 4'd0);
            MduBusy   = (state == BUSY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            StallCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MduStartE) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (StallF && (StallCnt != {CNT_W{1'b1}})) begin
                StallCnt <= StallCnt + 1'b1;
            end
        end
    end

endmodule
